xm23_mem_responder: RTL and testbench

Memory-side responder for the XM23 CPU's MAR/MDR bus. It accepts a four-phase request handshake carrying address, write data and the 3-bit bus control code, and performs the byte or word access on two byte-wide banks: even bytes in the low bank, odd bytes in the high bank. It then returns read data, an acknowledge and a bus-error flag. A combinational debug read port lets the front-panel viewer inspect memory without disturbing bus traffic.

---
 rtl/xm23_mem_responder.sv | 139 +++++++++++++
 tb/tb_xm23_mem_responder.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/xm23_mem_responder.sv
// xm23_mem_responder
//   Memory-side responder for the XM23 MAR/MDR bus. Accepts a four-phase
//   req/ack handshake, performs a byte or word access on two byte-wide banks
//   (even bytes in the low bank, odd bytes in the high bank), and returns read
//   data with a bus-error flag for misaligned word accesses. A combinational
//   debug port reads any word without touching the bus state machine.
//
// Ports
//   Clock, Reset   : system clock; asynchronous active-high reset
//   req            : request, held with addr/wdata/ctrl until ack rises
//   addr, wdata    : byte address (MAR) and write data (MDR)
//   ctrl           : [0]=write, [2]=byte, [1] ignored
//   ack            : access complete, held until req is sampled low
//   rdata, err     : read data and misaligned-word error, valid with ack
//   busy           : high whenever the responder is not idle
//   dbg_addr       : debug word address (bit 0 ignored)
//   dbg_data       : {high bank, low bank} at the debug word address
module xm23_mem_responder #(
  parameter int MEM_AW      = 15,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        req,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  input  logic [2:0]  ctrl,
  output logic        ack,
  output logic [15:0] rdata,
  output logic        err,
  output logic        busy,
  input  logic [15:0] dbg_addr,
  output logic [15:0] dbg_data
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_t;

  state_t state_q, state_d;

  logic [15:0] a_q, wd_q;
  logic        wr_q, byte_q;
  logic [3:0]  cnt_q;
  logic [15:0] rdata_q;
  logic        err_q;

  logic [7:0] lo_bank [2**MEM_AW];
  logic [7:0] hi_bank [2**MEM_AW];

  logic [MEM_AW-1:0] idx, dbg_idx;
  logic              misal;

  // Upper address bits alias onto the banks; these bits are intentionally
  // dropped, as are the reserved ctrl bit and the debug byte-select bit.
  logic unused_bits;
  assign unused_bits = ^{ctrl[1], a_q, dbg_addr};

  assign idx     = a_q[MEM_AW:1];
  assign dbg_idx = dbg_addr[MEM_AW:1];
  assign misal   = !byte_q && a_q[0];

  // State register
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (req) state_d = (WAIT_CYCLES > 0) ? S_WAIT : S_ACCESS;
      // Counter was loaded with WAIT_CYCLES, so leaving at 1 gives exactly
      // WAIT_CYCLES cycles in this state.
      S_WAIT:   if (cnt_q <= 4'd1) state_d = S_ACCESS;
      S_ACCESS: state_d = S_RESP;
      S_RESP:   if (!req) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy = (state_q != S_IDLE);
    ack  = (state_q == S_RESP);
  end

  assign rdata = rdata_q;
  assign err   = err_q;

  // Request latch, wait counter, response registers
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      a_q     <= '0;
      wd_q    <= '0;
      wr_q    <= 1'b0;
      byte_q  <= 1'b0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (req) begin
          a_q    <= addr;
          wd_q   <= wdata;
          wr_q   <= ctrl[0];
          byte_q <= ctrl[2];
          cnt_q  <= 4'(WAIT_CYCLES);
        end
        S_WAIT: cnt_q <= cnt_q - 4'd1;
        S_ACCESS: begin
          if (misal)        err_q <= 1'b1;
          else if (!wr_q) begin
            if (byte_q) rdata_q <= {8'h00, a_q[0] ? hi_bank[idx] : lo_bank[idx]};
            else        rdata_q <= {hi_bank[idx], lo_bank[idx]};
          end
        end
        S_RESP: if (!req) err_q <= 1'b0;
        default: ;
      endcase
    end
  end

  // Memory is not reset. Reset forces state_q out of ACCESS asynchronously,
  // so a write pending at reset never reaches the banks.
  always_ff @(posedge Clock) begin
    if (state_q == S_ACCESS && wr_q && !misal) begin
      if (byte_q) begin
        if (a_q[0]) hi_bank[idx] <= wd_q[7:0];
        else        lo_bank[idx] <= wd_q[7:0];
      end else begin
        lo_bank[idx] <= wd_q[7:0];
        hi_bank[idx] <= wd_q[15:8];
      end
    end
  end

  assign dbg_data = {hi_bank[dbg_idx], lo_bank[dbg_idx]};

endmodule

// File: tb/tb_xm23_mem_responder.sv
// Bench for xm23_mem_responder: two instances (small aliasing memory with no
// wait states, full-size memory with three wait states) checked against a
// byte-addressed reference memory.
module tb_xm23_mem_responder;

  localparam int AW0 = 4;
  localparam int AW1 = 15;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic        req      [2];
  logic [15:0] addr     [2];
  logic [15:0] wdata    [2];
  logic [2:0]  ctrl     [2];
  logic        ack      [2];
  logic [15:0] rdata    [2];
  logic        err      [2];
  logic        busy     [2];
  logic [15:0] dbg_addr [2];
  logic [15:0] dbg_data [2];

  always #5 Clock = ~Clock;

  xm23_mem_responder #(.MEM_AW(AW0), .WAIT_CYCLES(0)) u0 (
    .Clock(Clock), .Reset(Reset), .req(req[0]), .addr(addr[0]), .wdata(wdata[0]),
    .ctrl(ctrl[0]), .ack(ack[0]), .rdata(rdata[0]), .err(err[0]), .busy(busy[0]),
    .dbg_addr(dbg_addr[0]), .dbg_data(dbg_data[0]));

  xm23_mem_responder #(.MEM_AW(AW1), .WAIT_CYCLES(3)) u1 (
    .Clock(Clock), .Reset(Reset), .req(req[1]), .addr(addr[1]), .wdata(wdata[1]),
    .ctrl(ctrl[1]), .ack(ack[1]), .rdata(rdata[1]), .err(err[1]), .busy(busy[1]),
    .dbg_addr(dbg_addr[1]), .dbg_data(dbg_data[1]));

  // Reference: flat byte memory per instance, plus last returned read data.
  logic [7:0]  mdl     [2][65536];
  logic [15:0] prev_rd [2];
  int tests = 0;
  int fails = 0;

  function automatic logic [15:0] amask(input int d);
    return (d == 0) ? 16'((1 << (AW0 + 1)) - 1) : 16'((1 << (AW1 + 1)) - 1);
  endfunction

  function automatic int waits(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  function automatic logic [15:0] mword(input int d, input logic [15:0] a);
    logic [15:0] ia;
    ia = a & amask(d) & 16'hFFFE;
    return {mdl[d][ia | 16'h1], mdl[d][ia]};
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full handshake. Model is updated first; the DUT is then checked for
  // latency, response, optional hold-with-req-high, and the ack/err release.
  task automatic txn(input int d, input logic [15:0] a, input logic [15:0] wd,
                     input logic [2:0] c, input bit hold);
    logic [15:0] ia, exp_rd;
    logic        exp_err;
    int          k;
    ia = a & amask(d);
    exp_rd  = prev_rd[d];
    exp_err = 1'b0;
    if (!c[2] && a[0]) exp_err = 1'b1;
    else if (c[2]) begin
      if (c[0]) mdl[d][ia] = wd[7:0];
      else      exp_rd = {8'h00, mdl[d][ia]};
    end else begin
      if (c[0]) begin
        mdl[d][ia]         = wd[7:0];
        mdl[d][ia | 16'h1] = wd[15:8];
      end else exp_rd = mword(d, a);
    end
    prev_rd[d] = exp_rd;

    @(negedge Clock);
    addr[d] = a; wdata[d] = wd; ctrl[d] = c; req[d] = 1'b1;
    @(posedge Clock); #1;
    chk("busy_after_accept", 16'(busy[d]), 16'd1);
    chk("ack_low_after_accept", 16'(ack[d]), 16'd0);
    k = 1;
    while (!ack[d] && k < 40) begin
      @(posedge Clock); #1;
      if (!ack[d]) k++;
    end
    chk("ack_latency", 16'(k), 16'(1 + waits(d)));
    chk("ack_high", 16'(ack[d]), 16'd1);
    chk("err", 16'(err[d]), 16'(exp_err));
    chk("rdata", rdata[d], exp_rd);
    if (hold) begin
      @(posedge Clock); #1;
      chk("ack_held", 16'(ack[d]), 16'd1);
      chk("rdata_held", rdata[d], exp_rd);
      chk("err_held", 16'(err[d]), 16'(exp_err));
    end
    @(negedge Clock);
    req[d] = 1'b0;
    @(posedge Clock); #1;
    chk("ack_release", 16'(ack[d]), 16'd0);
    chk("err_release", 16'(err[d]), 16'd0);
    chk("busy_release", 16'(busy[d]), 16'd0);
    chk("rdata_kept", rdata[d], exp_rd);
  endtask

  task automatic dbg(input int d, input logic [15:0] a);
    dbg_addr[d] = a;
    #1;
    chk("dbg_data", dbg_data[d], mword(d, a));
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      req[d] = 1'b0; addr[d] = '0; wdata[d] = '0; ctrl[d] = '0; dbg_addr[d] = '0;
      prev_rd[d] = '0;
    end
    #1 Reset = 1'b1;
    #12;
    for (int d = 0; d < 2; d++) begin
      chk("rst_ack", 16'(ack[d]), 16'd0);
      chk("rst_err", 16'(err[d]), 16'd0);
      chk("rst_busy", 16'(busy[d]), 16'd0);
      chk("rst_rdata", rdata[d], 16'h0000);
    end
    @(negedge Clock) Reset = 1'b0;

    // Word write / read and debug view
    txn(0, 16'h0010, 16'h1234, 3'b001, 1'b0);
    txn(0, 16'h0010, 16'h0000, 3'b000, 1'b1);
    chk("word_rd_const", rdata[0], 16'h1234);
    dbg(0, 16'h0011);

    // Byte lanes
    txn(0, 16'h0011, 16'h00AB, 3'b101, 1'b0);
    txn(0, 16'h0010, 16'h0000, 3'b000, 1'b0);
    chk("byte_lane_word", rdata[0], 16'hAB34);
    txn(0, 16'h0010, 16'h0000, 3'b100, 1'b0);
    chk("byte_rd_lo", rdata[0], 16'h0034);
    txn(0, 16'h0011, 16'h0000, 3'b100, 1'b0);
    chk("byte_rd_hi", rdata[0], 16'h00AB);

    // Misaligned word write leaves memory untouched
    txn(0, 16'h0012, 16'h5A5A, 3'b001, 1'b0);
    txn(0, 16'h0013, 16'hFFFF, 3'b001, 1'b1);
    txn(0, 16'h0012, 16'h0000, 3'b000, 1'b0);
    chk("misal_unchanged", rdata[0], 16'h5A5A);
    dbg(0, 16'h0012);

    // Address aliasing on the small memory
    txn(0, 16'h0020, 16'hBEEF, 3'b001, 1'b0);
    txn(0, 16'h0000, 16'h0000, 3'b000, 1'b0);
    chk("wrap_read", rdata[0], 16'hBEEF);

    // Mid-cycle reset while in RESP, then acceptance on first edge after release
    @(negedge Clock);
    addr[0] = 16'h0010; ctrl[0] = 3'b000; req[0] = 1'b1;
    @(posedge Clock); @(posedge Clock); #2;
    Reset = 1'b1; #1;
    chk("midrst_ack", 16'(ack[0]), 16'd0);
    chk("midrst_err", 16'(err[0]), 16'd0);
    chk("midrst_busy", 16'(busy[0]), 16'd0);
    chk("midrst_rdata", rdata[0], 16'h0000);
    prev_rd[0] = '0; prev_rd[1] = '0;
    @(negedge Clock) Reset = 1'b0;
    @(posedge Clock); #1;
    chk("post_rst_accept", 16'(busy[0]), 16'd1);
    @(posedge Clock); #1;
    chk("post_rst_ack", 16'(ack[0]), 16'd1);
    chk("post_rst_rdata", rdata[0], mword(0, 16'h0010));
    prev_rd[0] = mword(0, 16'h0010);
    @(negedge Clock) req[0] = 1'b0;
    @(posedge Clock); #1;
    chk("post_rst_release", 16'(ack[0]), 16'd0);

    // Wait states and reset during WAIT
    txn(1, 16'h0010, 16'hAB34, 3'b001, 1'b0);
    txn(1, 16'h0010, 16'h0000, 3'b000, 1'b1);
    @(negedge Clock);
    addr[1] = 16'h0010; wdata[1] = 16'h5555; ctrl[1] = 3'b001; req[1] = 1'b1;
    @(posedge Clock); @(posedge Clock);
    @(negedge Clock);
    chk("in_wait_busy", 16'(busy[1]), 16'd1);
    Reset = 1'b1; req[1] = 1'b0; #1;
    chk("wait_rst_busy", 16'(busy[1]), 16'd0);
    prev_rd[0] = '0; prev_rd[1] = '0;
    @(negedge Clock) Reset = 1'b0;
    txn(1, 16'h0010, 16'h0000, 3'b000, 1'b0);
    chk("wait_rst_no_write", rdata[1], 16'hAB34);

    // Randomized traffic over fully initialised windows
    for (int i = 0; i < 32; i += 2) txn(0, 16'(i), 16'($urandom), 3'b001, 1'b0);
    for (int i = 0; i < 64; i += 2) txn(1, 16'(16'h0100 + i), 16'($urandom), 3'b001, 1'b0);
    for (int n = 0; n < 60; n++) begin
      int d;
      logic [15:0] a;
      d = n % 2;
      a = (d == 0) ? 16'($urandom_range(0, 63)) : 16'(16'h0100 + $urandom_range(0, 63));
      txn(d, a, 16'($urandom), 3'($urandom), 1'($urandom));
      dbg(d, (d == 0) ? 16'($urandom_range(0, 63)) : 16'(16'h0100 + $urandom_range(0, 63)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
